ifmap_spad_loader: RTL and testbench

//  Downstream consumer of the parallel-read input FIFO in the CNN PE.
//  - Pops PAR_READ-word groups from the FIFO and unpacks them to one word per cycle.
//  - Writes the words into a circular ifmap scratchpad.
//  - Tracks a sliding KSIZE-word window: flags win_ready for the MAC stage and frees STRIDE words per advance.
//  - Signals row_done once row_len words have been loaded and no further full window remains.

---
 rtl/ifmap_spad_loader_pkg.sv | 21 ++
 rtl/ifmap_spad_loader_par_unpacker.sv | 54 +++++
 rtl/ifmap_spad_loader.sv | 134 +++++++++++++
 tb/tb_ifmap_spad_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_spad_loader_pkg.sv
// ifmap_spad_loader_pkg
//   Shared definitions for the ifmap scratchpad loader: the FSM state
//   encoding, default word width and parallel-read factor (these must agree
//   with the input FIFO), and the scratchpad address-width helper.
package ifmap_spad_loader_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int PAR_READ_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Address width of a power-of-two scratchpad; a depth of 1 still gets one bit.
  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifmap_spad_loader_par_unpacker.sv
// ifmap_spad_loader_par_unpacker
//   Holds one PAR_READ-word group popped from the FIFO and presents it one
//   word per cycle, word0 first.
// Ports
//   clk, rst  clock, synchronous active-high reset
//   clear     drop any held words (row restart)
//   load      capture din, hold count becomes PAR_READ
//   shift     current word consumed, hold count decrements
//   din       packed group, word0 in the low WIDTH bits
//   word      word currently at the head of the hold register
//   cnt       number of words still held
module ifmap_spad_loader_par_unpacker
  import ifmap_spad_loader_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PAR_READ = PAR_READ_DEF,
  parameter int CNT_W    = $clog2(PAR_READ + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      load,
  input  logic                      shift,
  input  logic [WIDTH*PAR_READ-1:0] din,
  output logic [WIDTH-1:0]          word,
  output logic [CNT_W-1:0]          cnt
);

  logic [WIDTH-1:0] hold [PAR_READ];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < PAR_READ; i++) hold[i] <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      // A load may coincide with the last word's shift; the new group wins.
      cnt <= CNT_W'(PAR_READ);
      for (int i = 0; i < PAR_READ; i++) hold[i] <= din[i*WIDTH +: WIDTH];
    end else if (shift) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Head word index is PAR_READ-cnt; an empty register presents zero.
  always_comb begin
    word = '0;
    for (int i = 0; i < PAR_READ; i++) begin
      if (cnt == CNT_W'(PAR_READ - i)) word = hold[i];
    end
  end

endmodule

// File: rtl/ifmap_spad_loader.sv
// ifmap_spad_loader
//   Pops PAR_READ-word groups from the input FIFO, writes them one word per
//   cycle into a circular scratchpad, and tracks a sliding KSIZE-word window
//   for the MAC stage.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         begin a new row (also restarts a row in progress)
//   row_len       words in the row, sampled on start
//   fifo_valid    FIFO holds at least PAR_READ words
//   fifo_dout     packed FIFO group, word0 in the low bits
//   fifo_rd_en    FIFO pop strobe
//   spad_wen/waddr/wdata  scratchpad write port
//   win_base      scratchpad address of window word 0
//   win_ready     at least KSIZE valid words from win_base
//   win_advance   consumer done with the window (ignored unless win_ready)
//   row_done      single-cycle end-of-row pulse
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// LOAD  | popping, writing and tracking the window for the current row
// DONE  | row fully loaded and no full window left; row_done asserted
module ifmap_spad_loader
  import ifmap_spad_loader_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PAR_READ   = PAR_READ_DEF,
  parameter int SPAD_DEPTH = 16,
  parameter int KSIZE      = 4,
  parameter int STRIDE     = 1,
  parameter int LEN_W      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [LEN_W-1:0]                 row_len,
  input  logic                             fifo_valid,
  input  logic [WIDTH*PAR_READ-1:0]        fifo_dout,
  output logic                             fifo_rd_en,
  output logic                             spad_wen,
  output logic [calc_aw(SPAD_DEPTH)-1:0]   spad_waddr,
  output logic [WIDTH-1:0]                 spad_wdata,
  output logic [calc_aw(SPAD_DEPTH)-1:0]   win_base,
  output logic                             win_ready,
  input  logic                             win_advance,
  output logic                             row_done
);

  localparam int AW    = calc_aw(SPAD_DEPTH);
  localparam int CW    = AW + 1;
  localparam int CNT_W = $clog2(PAR_READ + 1);

  state_t           state, state_next;
  logic [LEN_W-1:0] len_r, loaded, loaded_next, popped;
  logic [CW-1:0]    count, count_next;
  logic [AW-1:0]    waddr, base;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
  logic [WIDTH-1:0] hold_word;
  logic             in_load, accepted;

  ifmap_spad_loader_par_unpacker #(
    .WIDTH    (WIDTH),
    .PAR_READ (PAR_READ),
    .CNT_W    (CNT_W)
  ) u_unpacker (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .load  (fifo_rd_en),
    .shift (spad_wen),
    .din   (fifo_dout),
    .word  (hold_word),
    .cnt   (hold_cnt)
  );

  assign in_load    = (state == ST_LOAD);
  assign spad_waddr = waddr;
  assign win_base   = base;
  assign spad_wdata = hold_word;

  always_comb begin
    spad_wen      = in_load && (hold_cnt != '0) && (count < CW'(SPAD_DEPTH));
    // Refill as the last held word is written so the write stream never gaps.
    fifo_rd_en    = in_load && fifo_valid && (popped < len_r) &&
                    ((hold_cnt == '0) || ((hold_cnt == CNT_W'(1)) && spad_wen));
    win_ready     = in_load && (count >= CW'(KSIZE));
    accepted      = win_advance && win_ready;
    row_done      = (state == ST_DONE);
    count_next    = count + CW'(spad_wen) - (accepted ? CW'(STRIDE) : CW'(0));
    loaded_next   = loaded + LEN_W'(spad_wen);
    hold_cnt_next = fifo_rd_en ? CNT_W'(PAR_READ) : (hold_cnt - CNT_W'(spad_wen));

    state_next = state;
    case (state)
      ST_IDLE: state_next = ST_IDLE;
      ST_LOAD: begin
        if ((loaded_next == len_r) && (hold_cnt_next == '0) && (count_next < CW'(KSIZE)))
          state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (start) state_next = ST_LOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      len_r  <= '0;
      loaded <= '0;
      popped <= '0;
      count  <= '0;
      waddr  <= '0;
      base   <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        len_r  <= row_len;
        loaded <= '0;
        popped <= '0;
        count  <= '0;
        waddr  <= '0;
        base   <= '0;
      end else begin
        count  <= count_next;
        loaded <= loaded_next;
        if (fifo_rd_en) popped <= popped + LEN_W'(PAR_READ);
        if (spad_wen)   waddr  <= waddr + AW'(1);
        if (accepted)   base   <= base + AW'(STRIDE);
      end
    end
  end

endmodule

// File: tb/tb_ifmap_spad_loader.sv
module tb_ifmap_spad_loader;
  localparam int WIDTH = 8, PAR_READ = 2, SPAD_DEPTH = 16, KSIZE = 4, STRIDE = 1, LEN_W = 8, AW = 4;

  logic clk = 1'b0;
  logic rst, start, fifo_valid, win_advance;
  logic [LEN_W-1:0] row_len;
  logic [WIDTH*PAR_READ-1:0] fifo_dout;
  logic fifo_rd_en, spad_wen, win_ready, row_done;
  logic [AW-1:0] spad_waddr, win_base;
  logic [WIDTH-1:0] spad_wdata;

  ifmap_spad_loader #(
    .WIDTH(WIDTH), .PAR_READ(PAR_READ), .SPAD_DEPTH(SPAD_DEPTH),
    .KSIZE(KSIZE), .STRIDE(STRIDE), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len),
    .fifo_valid(fifo_valid), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .spad_wen(spad_wen), .spad_waddr(spad_waddr), .spad_wdata(spad_wdata),
    .win_base(win_base), .win_ready(win_ready), .win_advance(win_advance),
    .row_done(row_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // Reference model: a row is active or just finished; words flow from the
  // source into a pending queue, then into the scratchpad one per cycle.
  bit m_active, m_done;
  int m_len, m_count, m_loaded, m_popped, m_waddr, m_base;
  logic [WIDTH-1:0] m_hold[$];
  logic [WIDTH-1:0] src[PAR_READ];
  bit seq_mode;
  int seq_next;

  int start_cyc, n_accept, n_done, n_writes, fourth_write_cyc, first_ready_cyc;
  int pop_log[$];
  int wr_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_len = 0; m_count = 0; m_loaded = 0;
    m_popped = 0; m_waddr = 0; m_base = 0;
    m_hold.delete();
  endtask

  task automatic refill();
    for (int i = 0; i < PAR_READ; i++) begin
      if (seq_mode) begin src[i] = WIDTH'(seq_next); seq_next++; end
      else src[i] = WIDTH'($urandom);
    end
  endtask

  task automatic clear_stats();
    n_accept = 0; n_done = 0; n_writes = 0; fourth_write_cyc = -1; first_ready_cyc = -1;
    pop_log.delete(); wr_log.delete();
  endtask

  // One clock: compare outputs with the model, then advance the model.
  task automatic step();
    bit e_wen, e_rd, e_rdy, acc;
    for (int i = 0; i < PAR_READ; i++) fifo_dout[i*WIDTH +: WIDTH] = src[i];
    #1;
    e_wen = m_active && (m_hold.size() > 0) && (m_count < SPAD_DEPTH);
    e_rd  = m_active && fifo_valid && (m_popped < m_len) &&
            ((m_hold.size() == 0) || (m_hold.size() == 1 && e_wen));
    e_rdy = m_active && (m_count >= KSIZE);
    acc   = win_advance && e_rdy;
    chk("fifo_rd_en", fifo_rd_en, e_rd);
    chk("spad_wen", spad_wen, e_wen);
    chk("spad_waddr", spad_waddr, m_waddr);
    chk("win_base", win_base, m_base);
    chk("win_ready", win_ready, e_rdy);
    chk("row_done", row_done, m_done);
    if (e_wen) chk("spad_wdata", spad_wdata, m_hold[0]);

    if (!rst && !start) begin
      if (acc) n_accept++;
      if (m_done) n_done++;
      if (e_rdy && first_ready_cyc < 0) first_ready_cyc = cyc - start_cyc;
      if (e_rd) pop_log.push_back(cyc - start_cyc);
      if (e_wen) begin
        n_writes++;
        wr_log.push_back(cyc - start_cyc);
        if (n_writes == KSIZE) fourth_write_cyc = cyc - start_cyc;
      end
    end

    if (rst) model_reset();
    else if (start) begin
      model_reset();
      m_active = 1;
      m_len = int'(row_len);
    end else begin
      if (e_wen) begin
        void'(m_hold.pop_front());
        m_waddr = (m_waddr + 1) % SPAD_DEPTH;
        m_count++;
        m_loaded++;
      end
      if (e_rd) begin
        for (int i = 0; i < PAR_READ; i++) m_hold.push_back(src[i]);
        m_popped += PAR_READ;
      end
      if (acc) begin
        m_base = (m_base + STRIDE) % SPAD_DEPTH;
        m_count -= STRIDE;
      end
      if (m_done) m_done = 0;
      else if (m_active && m_loaded == m_len && m_hold.size() == 0 && m_count < KSIZE) begin
        m_active = 0;
        m_done = 1;
      end
    end
    if (e_rd) refill();
    cyc++;
    @(negedge clk);
  endtask

  task automatic begin_row(input int len, input bit seq);
    seq_mode = seq; seq_next = 1; refill();
    clear_stats();
    start_cyc = cyc;
    row_len = LEN_W'(len); start = 1; win_advance = 0;
    step();
    start = 0;
  endtask

  // Run to the DONE cycle, then step through DONE and one idle cycle.
  task automatic finish_row(input int vpct, input int apct);
    int budget = 0;
    while (!m_done && budget < 3000) begin
      fifo_valid  = ($urandom_range(99) < vpct);
      win_advance = ($urandom_range(99) < apct);
      step();
      budget++;
    end
    if (!m_done) begin
      checks++; errors++;
      $error("FAIL row_timeout observed=%0d cycles expected=row_done", budget);
    end
    fifo_valid = 1; win_advance = 1;
    step();
    step();
  endtask

  initial begin
    rst = 1; start = 0; row_len = '0; fifo_valid = 1; win_advance = 0; fifo_dout = '0;
    seq_mode = 0; seq_next = 1;
    model_reset(); clear_stats(); refill();
    @(negedge clk);
    step();
    rst = 0;
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_wdata", spad_wdata, 0);
    chk("rst_waddr", spad_waddr, 0);
    step();

    // Reset in the middle of a row with the FIFO still valid.
    begin_row(8, 1);
    fifo_valid = 1;
    for (int i = 0; i < 5; i++) step();
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("midrst_rd_en", fifo_rd_en, 0);
    chk("midrst_wen", spad_wen, 0);
    chk("midrst_wdata", spad_wdata, 0);
    chk("midrst_ready", win_ready, 0);
    chk("midrst_base", win_base, 0);
    step();

    // Row of 8 sequential words, FIFO always valid, advance held high.
    begin_row(8, 1);
    fifo_valid = 1; win_advance = 1;
    for (int i = 0; i < 30 && !m_done; i++) step();
    chk("base_at_done", win_base, 5);
    chk("done_pulse", row_done, 1);
    step();
    step();
    chk("pops", pop_log.size(), 4);
    for (int i = 0; i < pop_log.size() && i < 4; i++) chk("pop_cycle", pop_log[i], 2 * i + 1);
    chk("writes", wr_log.size(), 8);
    for (int i = 0; i < wr_log.size() && i < 8; i++) chk("write_cycle", wr_log[i], i + 2);
    chk("first_ready", first_ready_cyc, fourth_write_cyc + 1);
    chk("accepted_adv", n_accept, 5);
    chk("done_count", n_done, 1);
    chk("idle_ready", win_ready, 0);

    // Fill to full with no advances, then free one word: write wraps to 0.
    begin_row(20, 1);
    fifo_valid = 1; win_advance = 0;
    for (int i = 0; i < 60 && m_count < SPAD_DEPTH; i++) step();
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("full_wen", spad_wen, 0);
    chk("full_rd", fifo_rd_en, 0);
    chk("full_ready", win_ready, 1);
    win_advance = 1;
    step();
    win_advance = 0;
    #1;
    chk("wrap_wen", spad_wen, 1);
    chk("wrap_addr", spad_waddr, 0);
    chk("wrap_data", spad_wdata, 17);
    step();
    finish_row(100, 100);

    // Restart while loading: pointers clear.
    begin_row(20, 0);
    for (int i = 0; i < 12; i++) begin
      fifo_valid = 1; win_advance = ($urandom_range(1) == 1);
      step();
    end
    fifo_valid = 0;
    begin_row(8, 0);
    #1;
    chk("restart_waddr", spad_waddr, 0);
    chk("restart_base", win_base, 0);
    chk("restart_ready", win_ready, 0);
    finish_row(70, 60);

    // Randomized rows.
    for (int r = 0; r < 8; r++) begin
      begin_row(2 * $urandom_range(2, 20), 0);
      finish_row($urandom_range(30, 100), $urandom_range(10, 90));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
